// File: rtl/core_types_pkg.sv
// Core-wide type and sizing definitions shared by the PRF writeback path.
// Bank of a PR is its low LOG_PRF_BANK_COUNT bits; the remaining bits select the row.
package core_types_pkg;

  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;
  localparam int LOG_PR_COUNT       = 7;
  localparam int LOG_ROB_ENTRIES    = 6;
  localparam int WB_REQUESTERS      = 4;

  typedef struct packed {
    logic                       valid;
    logic [31:0]                data;
    logic [LOG_PR_COUNT-1:0]    PR;
    logic [LOG_ROB_ENTRIES-1:0] ROB_index;
  } wb_req_t;

  function automatic logic [LOG_PRF_BANK_COUNT-1:0] pr_bank(input logic [LOG_PR_COUNT-1:0] pr);
    return pr[LOG_PRF_BANK_COUNT-1:0];
  endfunction

endpackage

// File: rtl/prf_wb_arbiter_bank_rr_arb.sv
// Round-robin arbiter for one PRF bank: grants the first requester at or after
// the pointer, wrapping, and moves the pointer just past the winner.
module wb_bank_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_index
);

  logic [IDX_W-1:0] ptr;
  logic             hi_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Descending scan so the lowest index ends up selected: lo_idx is the wrap
  // candidate, hi_idx the lowest requester at or above the pointer.
  always_comb begin
    hi_found    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    grant_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_valid = 1'b1;
        lo_idx      = IDX_W'(i);
        if (IDX_W'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    grant_index = hi_found ? hi_idx : lo_idx;
    grant       = '0;
    if (grant_valid) grant[grant_index] = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_index == IDX_W'(N - 1)) ? '0 : grant_index + 1'b1;
    end
  end

endmodule

// File: rtl/prf_wb_arbiter.sv
// PRF-side writeback responder: per-bank round-robin arbitration of the
// writeback requesters, then one registered stage to bank write, forward and ROB completion.
module prf_wb_arbiter
  import core_types_pkg::*;
#(
  parameter int WB_REQUESTERS = core_types_pkg::WB_REQUESTERS
) (
  input  logic                                                          CLK,
  input  logic                                                          nRST,
  input  logic [WB_REQUESTERS-1:0]                                      WB_valid_by_req,
  input  logic [WB_REQUESTERS-1:0][31:0]                                WB_data_by_req,
  input  logic [WB_REQUESTERS-1:0][LOG_PR_COUNT-1:0]                    WB_PR_by_req,
  input  logic [WB_REQUESTERS-1:0][LOG_ROB_ENTRIES-1:0]                 WB_ROB_index_by_req,
  output logic [WB_REQUESTERS-1:0]                                      WB_ready_by_req,
  output logic [PRF_BANK_COUNT-1:0]                                     bank_write_en,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] bank_write_index,
  output logic [PRF_BANK_COUNT-1:0][31:0]                               bank_write_data,
  output logic [PRF_BANK_COUNT-1:0]                                     forward_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]                   forward_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][31:0]                               forward_data_by_bank,
  output logic [PRF_BANK_COUNT-1:0]                                     complete_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_ROB_ENTRIES-1:0]                complete_ROB_index_by_bank
);

  localparam int N     = WB_REQUESTERS;
  localparam int B     = PRF_BANK_COUNT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  wb_req_t                               req [N];
  logic [B-1:0][N-1:0]                   bank_req;
  logic [B-1:0][N-1:0]                   bank_grant;
  logic [B-1:0]                          bank_grant_valid;
  logic [B-1:0][IDX_W-1:0]               bank_grant_index;
  logic [B-1:0][31:0]                    sel_data;
  logic [B-1:0][LOG_PR_COUNT-1:0]        sel_pr;
  logic [B-1:0][LOG_ROB_ENTRIES-1:0]     sel_rob;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i].valid     = WB_valid_by_req[i];
      req[i].data      = WB_data_by_req[i];
      req[i].PR        = WB_PR_by_req[i];
      req[i].ROB_index = WB_ROB_index_by_req[i];
    end
  end

  // Only valid and PR feed arbitration, so ready has no path from data or ROB index.
  // Requests are masked during reset so nothing is granted while nRST is low.
  always_comb begin
    bank_req = '0;
    for (int b = 0; b < B; b++) begin
      for (int i = 0; i < N; i++) begin
        bank_req[b][i] = nRST && req[i].valid &&
                         (pr_bank(req[i].PR) == LOG_PRF_BANK_COUNT'(b));
      end
    end
  end

  for (genvar b = 0; b < B; b++) begin : g_bank
    wb_bank_rr_arb #(
      .N     (N),
      .IDX_W (IDX_W)
    ) u_arb (
      .CLK         (CLK),
      .nRST        (nRST),
      .req         (bank_req[b]),
      .grant       (bank_grant[b]),
      .grant_valid (bank_grant_valid[b]),
      .grant_index (bank_grant_index[b])
    );
  end

  always_comb begin
    WB_ready_by_req = '0;
    for (int b = 0; b < B; b++) begin
      WB_ready_by_req = WB_ready_by_req | bank_grant[b];
    end
  end

  always_comb begin
    for (int b = 0; b < B; b++) begin
      sel_data[b] = req[bank_grant_index[b]].data;
      sel_pr[b]   = req[bank_grant_index[b]].PR;
      sel_rob[b]  = req[bank_grant_index[b]].ROB_index;
    end
  end

  // PR 0 is architecturally zero: it completes in the ROB but never writes or forwards.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bank_write_en              <= '0;
      bank_write_index           <= '0;
      bank_write_data            <= '0;
      forward_valid_by_bank      <= '0;
      forward_PR_by_bank         <= '0;
      forward_data_by_bank       <= '0;
      complete_valid_by_bank     <= '0;
      complete_ROB_index_by_bank <= '0;
    end else begin
      for (int b = 0; b < B; b++) begin
        bank_write_en[b]          <= bank_grant_valid[b] && (sel_pr[b] != '0);
        forward_valid_by_bank[b]  <= bank_grant_valid[b] && (sel_pr[b] != '0);
        complete_valid_by_bank[b] <= bank_grant_valid[b];
        if (bank_grant_valid[b]) begin
          bank_write_index[b]           <= sel_pr[b][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
          bank_write_data[b]            <= sel_data[b];
          forward_PR_by_bank[b]         <= sel_pr[b];
          forward_data_by_bank[b]       <= (sel_pr[b] != '0) ? sel_data[b] : '0;
          complete_ROB_index_by_bank[b] <= sel_rob[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Bench for prf_wb_arbiter: directed scenarios plus a random phase, with a
// scoreboard of accepted writebacks checked against the registered outputs.
module tb_prf_wb_arbiter;

  logic             CLK;
  logic             nRST;
  logic [3:0]       wb_valid;
  logic [3:0][31:0] wb_data;
  logic [3:0][6:0]  wb_pr;
  logic [3:0][5:0]  wb_rob;
  logic [3:0]       wb_ready;
  logic [3:0]       bank_write_en;
  logic [3:0][4:0]  bank_write_index;
  logic [3:0][31:0] bank_write_data;
  logic [3:0]       forward_valid_by_bank;
  logic [3:0][6:0]  forward_PR_by_bank;
  logic [3:0][31:0] forward_data_by_bank;
  logic [3:0]       complete_valid_by_bank;
  logic [3:0][5:0]  complete_ROB_index_by_bank;

  prf_wb_arbiter #(.WB_REQUESTERS(4)) dut (
    .CLK                        (CLK),
    .nRST                       (nRST),
    .WB_valid_by_req            (wb_valid),
    .WB_data_by_req             (wb_data),
    .WB_PR_by_req               (wb_pr),
    .WB_ROB_index_by_req        (wb_rob),
    .WB_ready_by_req            (wb_ready),
    .bank_write_en              (bank_write_en),
    .bank_write_index           (bank_write_index),
    .bank_write_data            (bank_write_data),
    .forward_valid_by_bank      (forward_valid_by_bank),
    .forward_PR_by_bank         (forward_PR_by_bank),
    .forward_data_by_bank       (forward_data_by_bank),
    .complete_valid_by_bank     (complete_valid_by_bank),
    .complete_ROB_index_by_bank (complete_ROB_index_by_bank)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model and scoreboard; entry = {bank[1:0], pr[6:0], data[31:0], rob[5:0]}
  logic [46:0] exp_q[$];
  int          m_ptr[4];
  int          m_gidx[4];
  logic [3:0]  m_ready;
  logic [6:0]  last_fpr[4];
  logic [31:0] last_fdata[4];
  int          wait_cnt[4];
  int          max_wait;

  task automatic model_reset();
    exp_q.delete();
    for (int b = 0; b < 4; b++) begin
      m_ptr[b]      = 0;
      last_fpr[b]   = '0;
      last_fdata[b] = '0;
      wait_cnt[b]   = 0;
    end
    max_wait = 0;
  endtask

  task automatic model_arb();
    m_ready = '0;
    for (int b = 0; b < 4; b++) begin
      m_gidx[b] = -1;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr[b] + k) % 4;
        if (m_gidx[b] < 0 && wb_valid[i] && wb_pr[i][1:0] == 2'(b)) begin
          m_gidx[b]  = i;
          m_ready[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/ready"}, wb_ready, 0);
    check({tag, "/wen"}, bank_write_en, 0);
    check({tag, "/windex"}, bank_write_index, 0);
    check({tag, "/wdata"}, bank_write_data, 0);
    check({tag, "/fvalid"}, forward_valid_by_bank, 0);
    check({tag, "/fpr"}, forward_PR_by_bank, 0);
    check({tag, "/fdata"}, forward_data_by_bank, 0);
    check({tag, "/cvalid"}, complete_valid_by_bank, 0);
    check({tag, "/crob"}, complete_ROB_index_by_bank, 0);
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0]  hit;
    logic [46:0] e;
    int          b;
    logic [6:0]  pr;
    logic [31:0] data;
    logic [5:0]  rob;
    hit = '0;
    while (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      b    = int'(e[46:45]);
      pr   = e[44:38];
      data = e[37:6];
      rob  = e[5:0];
      hit[b] = 1'b1;
      check($sformatf("%s/wen%0d", tag, b), bank_write_en[b], pr != 0);
      check($sformatf("%s/fvalid%0d", tag, b), forward_valid_by_bank[b], pr != 0);
      if (pr != 0) begin
        check($sformatf("%s/windex%0d", tag, b), bank_write_index[b], pr[6:2]);
        check($sformatf("%s/wdata%0d", tag, b), bank_write_data[b], data);
      end
      check($sformatf("%s/cvalid%0d", tag, b), complete_valid_by_bank[b], 1);
      check($sformatf("%s/crob%0d", tag, b), complete_ROB_index_by_bank[b], rob);
      last_fpr[b]   = pr;
      last_fdata[b] = (pr != 0) ? data : 32'h0;
    end
    for (int k = 0; k < 4; k++) begin
      if (!hit[k]) begin
        check($sformatf("%s/idle_wen%0d", tag, k), bank_write_en[k], 0);
        check($sformatf("%s/idle_fvalid%0d", tag, k), forward_valid_by_bank[k], 0);
        check($sformatf("%s/idle_cvalid%0d", tag, k), complete_valid_by_bank[k], 0);
      end
      check($sformatf("%s/fpr%0d", tag, k), forward_PR_by_bank[k], last_fpr[k]);
      check($sformatf("%s/fdata%0d", tag, k), forward_data_by_bank[k], last_fdata[k]);
    end
  endtask

  // driver: called right after a negedge with inputs already applied
  task automatic step(input string tag);
    #1;
    model_arb();
    check({tag, "/ready"}, wb_ready, m_ready);
    for (int b = 0; b < 4; b++) begin
      if (m_gidx[b] >= 0) begin
        exp_q.push_back({2'(b), wb_pr[m_gidx[b]], wb_data[m_gidx[b]], wb_rob[m_gidx[b]]});
        m_ptr[b] = (m_gidx[b] + 1) % 4;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (wb_valid[i] && !m_ready[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
    @(posedge CLK);
    @(negedge CLK);
    check_outputs(tag);
  endtask

  task automatic peek(input string tag, input logic [3:0] exp);
    #1;
    check(tag, wb_ready, exp);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (wb_valid != 0 && n < 16) begin
      step(tag);
      wb_valid = wb_valid & ~m_ready;
      n++;
    end
    if (wb_valid != 0) check({tag, "/drain_timeout"}, wb_valid, 0);
    wb_valid = '0;
    step({tag, "_flush"});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    wb_data  = '0;
    wb_rob   = '0;
    wb_pr    = {7'h03, 7'h02, 7'h01, 7'h05};
    wb_valid = 4'hF;
    nRST     = 1'b0;
    model_reset();

    // reset: valid requests must not be granted, outputs all zero
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    wb_valid = '0;
    nRST     = 1'b1;
    @(negedge CLK);

    // single writeback to bank 1
    wb_valid[0] = 1'b1; wb_pr[0] = 7'd5; wb_data[0] = 32'hDEADBEEF; wb_rob[0] = 6'd9;
    peek("single/ready", 4'b0001);
    step("single");
    wb_valid = '0;
    step("single_out");
    for (int b = 0; b < 4; b++) begin
      if (b != 1) begin
        check($sformatf("single/other_wdata%0d", b), bank_write_data[b], 0);
        check($sformatf("single/other_crob%0d", b), complete_ROB_index_by_bank[b], 0);
      end
    end

    // conflict on bank 0
    wb_valid = 4'b0011;
    wb_pr[0] = 7'd4; wb_data[0] = 32'hA0A0A0A0; wb_rob[0] = 6'd1;
    wb_pr[1] = 7'd8; wb_data[1] = 32'hB1B1B1B1; wb_rob[1] = 6'd2;
    peek("conflict/T", 4'b0001);
    step("conflict_T");
    wb_valid = 4'b0010;
    peek("conflict/T1", 4'b0010);
    step("conflict_T1");
    wb_valid = '0;
    step("conflict_T2");

    // bank 0 pointer now 2: three-way conflict must pick requester 2 first
    wb_valid = 4'b0111;
    wb_pr[0] = 7'h0C; wb_pr[1] = 7'h10; wb_pr[2] = 7'h14;
    wb_data[2] = 32'hC2C2C2C2; wb_rob[2] = 6'd7;
    peek("ptr0/after_conflict", 4'b0100);
    drain("ptr0");

    // parallel: one requester per bank
    wb_valid = 4'hF;
    wb_pr = {7'h43, 7'h32, 7'h21, 7'h10};
    for (int i = 0; i < 4; i++) begin
      wb_data[i] = 32'h11110000 + i;
      wb_rob[i]  = 6'(20 + i);
    end
    peek("parallel/ready", 4'hF);
    step("parallel");
    wb_valid = '0;
    step("parallel_out");

    // PR 0 completes but does not write or forward
    wb_valid = 4'b0100; wb_pr[2] = 7'd0; wb_data[2] = 32'h12345678; wb_rob[2] = 6'd3;
    peek("pr0/ready", 4'b0100);
    step("pr0");
    wb_valid = '0;
    step("pr0_out");
    check("pr0/fdata0", forward_data_by_bank[0], 0);

    // reset right after an accept on bank 2 drops it and clears the pointer
    wb_valid = 4'b0010; wb_pr[1] = 7'h06; wb_data[1] = 32'h55AA55AA; wb_rob[1] = 6'd11;
    peek("rst/ready", 4'b0010);
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    wb_valid = '0;
    check_all_zero("rst/mid");
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    step("rst_idle");

    // fairness: all four hammer bank 2, grants must rotate 0,1,2,3,0
    wb_valid = 4'hF;
    wb_pr = {7'h0E, 7'h0A, 7'h06, 7'h02};
    max_wait = 0;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] want;
      want = 4'b0001 << (k % 4);
      for (int i = 0; i < 4; i++) begin
        wb_data[i] = $urandom;
        wb_rob[i]  = 6'($urandom_range(0, 63));
      end
      peek($sformatf("fair/grant%0d", k), want);
      step("fair");
    end
    wb_valid = '0;
    step("fair_flush");
    check("fair/max_wait", max_wait, 3);

    // random traffic with requester stall
    max_wait = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!wb_valid[i] && $urandom_range(0, 1) == 1) begin
          wb_valid[i] = 1'b1;
          wb_pr[i]    = 7'($urandom_range(0, 127));
          wb_data[i]  = $urandom;
          wb_rob[i]   = 6'($urandom_range(0, 63));
        end
      end
      step("rand");
      wb_valid = wb_valid & ~m_ready;
    end
    drain("rand_end");
    check("rand/max_wait_le3", max_wait <= 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
